// File: rtl/vcpu_pkg.sv
// Shared vcpu definitions: immediate-select format codes, base opcodes and an
// immediate range helper used by the instruction encoder.
package vcpu_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_J = 3'd4,
        FMT_U = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // True when v is representable as a two's-complement number of 'bits' bits:
    // everything from the sign position upwards must be all zeros or all ones.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (bits - 1);
        return ((v & mask) == 32'd0) || ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: builds the instruction word for the given
// format and flags whether the opcode/immediate combination is encodable.
module instr_pack
    import vcpu_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    // NOTE: defaults at the top of an always_comb keep every path assigned, so
    // no latch is inferred for format codes that have no case item.
    always_comb begin
        instr = '0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = (opcode == OP_R);
            end
            FMT_I: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                legal = (opcode == OP_IMM || opcode == OP_LOAD || opcode == OP_JALR)
                        && fits_signed(imm, 12);
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = (opcode == OP_STORE) && fits_signed(imm, 12);
            end
            FMT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = (opcode == OP_BRANCH) && fits_signed(imm, 13) && !imm[0];
            end
            FMT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = (opcode == OP_JAL) && fits_signed(imm, 21) && !imm[0];
            end
            FMT_U: begin
                instr = {imm[31:12], rd, opcode};
                legal = (opcode == OP_AUIPC || opcode == OP_LUI) && (imm[11:0] == 12'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams packed RV32I words with their instruction-memory addresses through a
// 2-entry output skid buffer; illegal bundles are consumed, counted and dropped.
module instr_encoder
    import vcpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_last,
    input  logic [2:0]        i_fmt,
    input  logic [6:0]        i_opcode,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [31:0]       i_imm,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_done,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_count,
    output logic [CNT_W-1:0]  o_err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e            state;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        cnt;
    logic [1:0]        cnt_next;
    logic [31:0]       slot_instr;
    logic [ADDR_W-1:0] slot_addr;
    logic [31:0]       pack_instr;
    logic              pack_legal;
    logic              accept;
    logic              push;
    logic              pop;

    instr_pack u_pack (
        .fmt    (i_fmt),
        .opcode (i_opcode),
        .rd     (i_rd),
        .rs1    (i_rs1),
        .rs2    (i_rs2),
        .funct3 (i_funct3),
        .funct7 (i_funct7),
        .imm    (i_imm),
        .instr  (pack_instr),
        .legal  (pack_legal)
    );

    assign accept = i_valid && o_ready;
    assign push   = accept && pack_legal;
    assign pop    = o_valid && i_ready;

    always_comb begin
        cnt_next = cnt;
        if (push && !pop)
            cnt_next = cnt + 2'd1;
        else if (pop && !push)
            cnt_next = cnt - 2'd1;
    end

    // The head entry is the output register itself; slot_* holds the second word.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the buffer entries are reset too so a mid-program
    // reset leaves no stale word visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            cnt        <= 2'd0;
            slot_instr <= '0;
            slot_addr  <= '0;
            o_ready    <= 1'b0;
            o_valid    <= 1'b0;
            o_instr    <= '0;
            o_addr     <= '0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_count    <= '0;
            o_err_cnt  <= '0;
        end else begin
            cnt     <= cnt_next;
            o_valid <= (cnt_next != 2'd0);

            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state     <= S_RUN;
                        addr      <= i_base & ~ADDR_W'(3);
                        o_count   <= '0;
                        o_err_cnt <= '0;
                        o_err     <= 1'b0;
                        o_done    <= 1'b0;
                        o_ready   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept && i_last) begin
                        state   <= S_DRAIN;
                        o_ready <= 1'b0;
                    end else begin
                        o_ready <= (cnt_next != 2'd2);
                    end
                end
                S_DRAIN: begin
                    if (cnt == 2'd0) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (push)
                addr <= addr + ADDR_W'(4);

            if (accept && !pack_legal) begin
                o_err <= 1'b1;
                if (o_err_cnt != '1)
                    o_err_cnt <= o_err_cnt + CNT_W'(1);
            end

            if (pop && o_count != '1)
                o_count <= o_count + CNT_W'(1);

            // A push while full cannot happen because o_ready is low when full.
            if (pop && cnt == 2'd2) begin
                o_instr <= slot_instr;
                o_addr  <= slot_addr;
            end else if (push && (cnt == 2'd0 || pop)) begin
                o_instr <= pack_instr;
                o_addr  <= addr;
            end else if (push) begin
                slot_instr <= pack_instr;
                slot_addr  <= addr;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed programs plus random bundles,
// compared every cycle against a queue-based behavioural model.
module tb_instr_encoder;
    import vcpu_pkg::*;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_start;
    logic [ADDR_W-1:0] i_base;
    logic              i_valid;
    logic              o_ready;
    logic              i_last;
    logic [2:0]        i_fmt;
    logic [6:0]        i_opcode;
    logic [4:0]        i_rd;
    logic [4:0]        i_rs1;
    logic [4:0]        i_rs2;
    logic [2:0]        i_funct3;
    logic [6:0]        i_funct7;
    logic [31:0]       i_imm;
    logic              o_valid;
    logic              i_ready;
    logic [31:0]       o_instr;
    logic [ADDR_W-1:0] o_addr;
    logic              o_done;
    logic              o_err;
    logic [CNT_W-1:0]  o_count;
    logic [CNT_W-1:0]  o_err_cnt;

    instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_base    (i_base),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_last    (i_last),
        .i_fmt     (i_fmt),
        .i_opcode  (i_opcode),
        .i_rd      (i_rd),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_funct3  (i_funct3),
        .i_funct7  (i_funct7),
        .i_imm     (i_imm),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_instr   (o_instr),
        .o_addr    (o_addr),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_count   (o_count),
        .o_err_cnt (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        last;
    } bundle_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } word_t;

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_e;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding built from shifts and masks on the byte-valued immediate.
    function automatic logic [31:0] model_enc(input bundle_t b);
        logic [31:0] imm;
        logic [31:0] base;
        imm  = b.imm;
        base = 32'(b.op) | (32'(b.f3) << 12) | (32'(b.rs1) << 15);
        case (b.fmt)
            3'd0: return base | (32'(b.rd) << 7) | (32'(b.rs2) << 20) | (32'(b.f7) << 25);
            3'd1: return base | (32'(b.rd) << 7) | ((imm & 32'hFFF) << 20);
            3'd2: return base | (32'(b.rs2) << 20) | ((imm & 32'h1F) << 7)
                              | (((imm >> 5) & 32'h7F) << 25);
            3'd3: return base | (32'(b.rs2) << 20) | (((imm >> 12) & 32'h1) << 31)
                              | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                              | (((imm >> 11) & 32'h1) << 7);
            3'd4: return 32'(b.op) | (32'(b.rd) << 7) | (((imm >> 20) & 32'h1) << 31)
                              | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                              | (((imm >> 12) & 32'hFF) << 12);
            3'd5: return 32'(b.op) | (32'(b.rd) << 7) | (imm & 32'hFFFF_F000);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit model_legal(input bundle_t b);
        int s;
        s = $signed(b.imm);
        case (b.fmt)
            3'd0: return b.op == 7'b0110011;
            3'd1: return (b.op == 7'b0010011 || b.op == 7'b0000011 || b.op == 7'b1100111)
                         && s >= -2048 && s <= 2047;
            3'd2: return b.op == 7'b0100011 && s >= -2048 && s <= 2047;
            3'd3: return b.op == 7'b1100011 && s >= -4096 && s <= 4095 && (s % 2 == 0);
            3'd4: return b.op == 7'b1101111 && s >= -1048576 && s <= 1048575 && (s % 2 == 0);
            3'd5: return (b.op == 7'b0010111 || b.op == 7'b0110111) && (b.imm[11:0] == 12'd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bundle_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm,
                                   input logic last);
        bundle_t b;
        b.fmt = fmt; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
        b.f3 = f3; b.f7 = f7; b.imm = imm; b.last = last;
        return b;
    endfunction

    // Behavioural model state, advanced once per cycle by the compare process.
    word_t       mq[$];
    word_t       log_q[$];
    mstate_e     mstate;
    logic [31:0] maddr;
    logic [15:0] mcount;
    logic [15:0] merrcnt;
    logic        merr;
    logic        prev_stall;
    logic [31:0] prev_instr;
    logic [31:0] prev_addr;

    always @(negedge i_clk) begin
        bundle_t cur;
        word_t   w;
        bit      emit;
        bit      acc;
        if (!i_rst_n) begin
            mq.delete();
            mstate     = M_IDLE;
            maddr      = 32'd0;
            mcount     = 16'd0;
            merrcnt    = 16'd0;
            merr       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("o_valid", 64'(o_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("o_instr", 64'(o_instr), 64'(mq[0].instr));
                check("o_addr", 64'(o_addr), 64'(mq[0].addr));
            end
            if (prev_stall) begin
                check("hold_instr", 64'(o_instr), 64'(prev_instr));
                check("hold_addr", 64'(o_addr), 64'(prev_addr));
            end
            check("o_ready", 64'(o_ready), 64'(mstate == M_RUN && mq.size() < 2));
            check("o_done", 64'(o_done), 64'(mstate == M_DONE));
            check("o_err", 64'(o_err), 64'(merr));
            check("o_count", 64'(o_count), 64'(mcount));
            check("o_err_cnt", 64'(o_err_cnt), 64'(merrcnt));

            emit       = o_valid && i_ready;
            acc        = i_valid && o_ready;
            prev_stall = o_valid && !i_ready;
            prev_instr = o_instr;
            prev_addr  = o_addr;
            cur = mk(i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_last);

            case (mstate)
                M_IDLE, M_DONE: if (i_start) begin
                    mstate  = M_RUN;
                    maddr   = {i_base[31:2], 2'b00};
                    mcount  = 16'd0;
                    merrcnt = 16'd0;
                    merr    = 1'b0;
                end
                M_RUN:   if (acc && i_last) mstate = M_DRAIN;
                M_DRAIN: if (mq.size() == 0) mstate = M_DONE;
                default: ;
            endcase

            if (emit && mq.size() != 0) begin
                log_q.push_back(mq.pop_front());
                if (mcount != 16'hFFFF) mcount = mcount + 16'd1;
            end
            if (acc) begin
                if (model_legal(cur)) begin
                    w.instr = model_enc(cur);
                    w.addr  = maddr;
                    mq.push_back(w);
                    maddr = maddr + 32'd4;
                end else begin
                    merr = 1'b1;
                    if (merrcnt != 16'hFFFF) merrcnt = merrcnt + 16'd1;
                end
            end
        end
    end

    bit rand_ready = 1'b0;

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input bundle_t b);
        i_fmt = b.fmt; i_opcode = b.op; i_rd = b.rd; i_rs1 = b.rs1; i_rs2 = b.rs2;
        i_funct3 = b.f3; i_funct7 = b.f7; i_imm = b.imm; i_last = b.last;
    endtask

    task automatic send(input bundle_t b);
        bit acc;
        drive(b);
        i_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 64 && !acc; k++) begin
            acc = o_ready;
            tick();
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic start(input logic [31:0] base);
        i_base  = base;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400 && !o_done; k++) tick();
        check("done_timeout", 64'(o_done), 64'd1);
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] instr,
                             input logic [31:0] addr);
        if (idx < log_q.size()) begin
            check({name, "_instr"}, 64'(log_q[idx].instr), 64'(instr));
            check({name, "_addr"}, 64'(log_q[idx].addr), 64'(addr));
        end else begin
            check({name, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
        end
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t     b;
        logic [11:0] t12;
        logic [12:0] t13;
        logic [20:0] t21;
        b.fmt = (($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5)));
        case (b.fmt)
            3'd0: b.op = OP_R;
            3'd1: begin
                case ($urandom_range(0, 2))
                    0: b.op = OP_IMM;
                    1: b.op = OP_LOAD;
                    default: b.op = OP_JALR;
                endcase
            end
            3'd2: b.op = OP_STORE;
            3'd3: b.op = OP_BRANCH;
            3'd4: b.op = OP_JAL;
            3'd5: b.op = ($urandom_range(0, 1) == 0) ? OP_LUI : OP_AUIPC;
            default: b.op = 7'($urandom);
        endcase
        if ($urandom_range(0, 5) == 0) b.op = 7'($urandom);
        t12 = 12'($urandom);
        t13 = 13'($urandom);
        t21 = 21'($urandom);
        case ($urandom_range(0, 4))
            0: b.imm = $urandom;
            1: b.imm = {{20{t12[11]}}, t12};
            2: b.imm = {{19{t13[12]}}, t13} & ~32'd1;
            3: b.imm = {{11{t21[20]}}, t21} & ~32'd1;
            default: b.imm = $urandom & 32'hFFFF_F000;
        endcase
        if ($urandom_range(0, 7) == 0) b.imm = b.imm | 32'd1;
        b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        b.f3 = 3'($urandom); b.f7 = 7'($urandom);
        b.last = 1'b0;
        return b;
    endfunction

    bundle_t b_addi, b_add, b_sw, b_beq, b_jal, b_lui, b_bad_b, b_bad_fmt, b_bad_op;

    initial begin
        bundle_t rb;
        b_addi    = mk(3'd1, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         1'b0);
        b_add     = mk(3'd0, OP_R,      5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 1'b0);
        b_sw      = mk(3'd2, OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         1'b1);
        b_beq     = mk(3'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
        b_jal     = mk(3'd4, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,         1'b0);
        b_lui     = mk(3'd5, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
        b_bad_b   = mk(3'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,         1'b0);
        b_bad_fmt = mk(3'd7, OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,         1'b0);
        b_bad_op  = mk(3'd1, OP_R,      5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,         1'b0);

        i_rst_n = 1'b0; i_start = 1'b0; i_base = '0; i_valid = 1'b0; i_ready = 1'b1;
        drive(b_addi);
        i_last = 1'b0;

        // Hand-computed words pin the reference model.
        check("model_addi", 64'(model_enc(b_addi)), 64'h0050_0093);
        check("model_add",  64'(model_enc(b_add)),  64'h0020_81B3);
        check("model_sw",   64'(model_enc(b_sw)),   64'h0020_A423);
        check("model_beq",  64'(model_enc(b_beq)),  64'hFE20_8EE3);
        check("model_jal",  64'(model_enc(b_jal)),  64'h0080_00EF);
        check("model_lui",  64'(model_enc(b_lui)),  64'h1234_52B7);
        check("model_bad_b",   64'(model_legal(b_bad_b)),   64'd0);
        check("model_bad_fmt", 64'(model_legal(b_bad_fmt)), 64'd0);
        check("model_bad_op",  64'(model_legal(b_bad_op)),  64'd0);

        tick(); tick();
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_instr", 64'(o_instr), 64'd0);
        check("rst_addr",  64'(o_addr),  64'd0);
        check("rst_done",  64'(o_done),  64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        i_rst_n = 1'b1;
        tick();

        // Program 1: addi, add, sw with full downstream throughput.
        log_q.delete();
        start(32'h100);
        send(b_addi); send(b_add); send(b_sw);
        wait_done();
        check_log("p1_w0", 0, 32'h0050_0093, 32'h100);
        check_log("p1_w1", 1, 32'h0020_81B3, 32'h104);
        check_log("p1_w2", 2, 32'h0020_A423, 32'h108);
        check("p1_count", 64'(o_count), 64'd3);

        // Program 2: unaligned base, illegal bundles in between legal ones.
        log_q.delete();
        start(32'h203);
        send(b_beq); send(b_jal);
        send(b_bad_b);
        check("p2_err", 64'(o_err), 64'd1);
        check("p2_err_cnt1", 64'(o_err_cnt), 64'd1);
        send(b_bad_fmt); send(b_bad_op);
        send(b_lui);
        wait_done();
        check_log("p2_w0", 0, 32'hFE20_8EE3, 32'h200);
        check_log("p2_w1", 1, 32'h0080_00EF, 32'h204);
        check_log("p2_w2", 2, 32'h1234_52B7, 32'h208);
        check("p2_err_cnt3", 64'(o_err_cnt), 64'd3);
        check("p2_count", 64'(o_count), 64'd3);

        // Program 3: downstream stalled while three bundles are offered.
        log_q.delete();
        i_ready = 1'b0;
        start(32'h1000);
        send(b_addi); send(b_add);
        drive(b_sw);
        i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("stall_ready", 64'(o_ready), 64'd0);
            check("stall_valid", 64'(o_valid), 64'd1);
            check("stall_instr", 64'(o_instr), 64'h0050_0093);
            tick();
        end
        i_ready = 1'b1;
        send(b_sw);
        wait_done();
        check_log("p3_w0", 0, 32'h0050_0093, 32'h1000);
        check_log("p3_w1", 1, 32'h0020_81B3, 32'h1004);
        check_log("p3_w2", 2, 32'h0020_A423, 32'h1008);

        // Program 4: random bundles and random backpressure, address wraps.
        log_q.delete();
        rand_ready = 1'b1;
        start(32'hFFFF_FFF0);
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) tick();
            rb = rand_bundle();
            rb.last = (n == 79);
            send(rb);
        end
        wait_done();
        rand_ready = 1'b0;
        i_ready = 1'b1;
        check("p4_count", 64'(o_count), 64'(log_q.size()));

        // Program 5: asynchronous reset with two words buffered.
        start(32'h40);
        b_jal.last = 1'b0;
        send(b_addi);
        tick();
        i_ready = 1'b0;
        send(b_add);
        b_sw.last = 1'b0;
        send(b_sw);
        check("p5_pre_valid", 64'(o_valid), 64'd1);
        check("p5_pre_count", 64'(o_count), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check("p5_rst_valid", 64'(o_valid), 64'd0);
        check("p5_rst_ready", 64'(o_ready), 64'd0);
        check("p5_rst_count", 64'(o_count), 64'd0);
        check("p5_rst_done",  64'(o_done),  64'd0);
        tick(); tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        log_q.delete();
        start(32'h80);
        b_jal.last = 1'b1;
        send(b_jal);
        wait_done();
        check("p5_words", 64'(log_q.size()), 64'd1);
        check_log("p5_w0", 0, 32'h0080_00EF, 32'h80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
